// File: rtl/gpu_pkg.sv
// gpu_pkg -- definitions shared by the VRAM arbiter and its write queue.
//
// Contents:
//   arb_state_t   : arbiter top-level states (IDLE, CLEAR)
//   grant_t       : which requester owns the memory port this cycle
//   BLANK_CODE    : character code written by a screen clear (space)
//   CHARS_DEFAULT : number of visible character cells (40x30)
package gpu_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2,
    GNT_CLEAR = 2'd3
  } grant_t;

  localparam logic [7:0] BLANK_CODE    = 8'h20;
  localparam int         CHARS_DEFAULT = 1200;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo -- in-order queue of pending CPU writes (address + data).
//
// Parameters:
//   ADDR_W, DATA_W : entry field widths
//   DEPTH          : number of entries, must be a power of two (>= 2)
// Ports:
//   clk, clr                          : clock, asynchronous active-low reset
//   push, push_addr, push_data        : enqueue (ignored when full)
//   pop                               : dequeue head (ignored when empty)
//   head_addr, head_data              : current head entry
//   full, empty                       : occupancy flags
module vram_wr_fifo #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_data = data_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
      data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one synchronous single-port character RAM between
// the renderer (reads, highest priority), queued CPU writes and an optional
// hardware screen clear.
//
// Optional feature: define VRAM_CLEAR_EN to build the CLEAR state, its
// address counter and clear_done. Without it clear_start is ignored and
// clear_busy/clear_done are tied low.
//
// Ports:
//   clk, clr                         : clock, asynchronous active-low reset
//   rd_req, rd_addr                  : renderer fetch request
//   rd_data, rd_valid                : fetched code, valid one cycle later
//   cpu_wr_valid/addr/data, ready    : CPU write channel into the queue
//   wr_drop                          : pulse when an out-of-range write is discarded
//   clear_start, clear_busy, clear_done : screen clear control/status
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : RAM port (1-cycle read latency)
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int CHARS      = CHARS_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  output logic              wr_drop,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   CHARS_EXT = (ADDR_W+1)'(CHARS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHARS - 1);

  grant_t            grant;
  logic              clearing;
  logic [ADDR_W-1:0] clear_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              head_in_range;
  logic              en_raw;
  logic              we_raw;

  assign cpu_wr_ready  = !fifo_full;
  assign push          = cpu_wr_valid && !fifo_full;
  assign head_in_range = ({1'b0, head_addr} < CHARS_EXT);

  vram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_addr (cpu_wr_addr),
    .push_data (cpu_wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One owner per cycle: renderer first, then the clear sweep, then the
  // queue head. While clearing the queue keeps filling but is not drained.
  always_comb begin
    grant = GNT_NONE;
    if (rd_req)           grant = GNT_READ;
    else if (clearing)    grant = GNT_CLEAR;
    else if (!fifo_empty) grant = GNT_WRITE;
  end

  assign pop     = (grant == GNT_WRITE);
  assign wr_drop = pop && !head_in_range;

  // An out-of-range head is still popped, it just never reaches the RAM.
  always_comb begin
    en_raw    = 1'b0;
    we_raw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_READ: begin
        en_raw   = 1'b1;
        mem_addr = rd_addr;
      end
      GNT_WRITE: begin
        if (head_in_range) begin
          en_raw    = 1'b1;
          we_raw    = 1'b1;
          mem_addr  = head_addr;
          mem_wdata = head_data;
        end
      end
      GNT_CLEAR: begin
        en_raw    = 1'b1;
        we_raw    = 1'b1;
        mem_addr  = clear_addr;
        mem_wdata = DATA_W'(BLANK_CODE);
      end
      default: begin
        en_raw = 1'b0;
      end
    endcase
  end

  // The RAM must see no access while reset is held, even if rd_req is up.
  assign mem_en = clr && en_raw;
  assign mem_we = clr && we_raw;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rd_valid <= 1'b0;
    else      rd_valid <= rd_req;
  end

  // The RAM already registers its output, so in the cycle after the read the
  // code is on mem_rdata; it is presented only while rd_valid is high.
  assign rd_data = rd_valid ? mem_rdata : '0;

`ifdef VRAM_CLEAR_EN
  arb_state_t        state;
  logic [ADDR_W-1:0] clear_cnt;
  logic              clear_done_q;

  assign clearing   = (state == CLEAR);
  assign clear_addr = clear_cnt;
  assign clear_busy = clearing;
  assign clear_done = clear_done_q;

  // Clear sweep: the counter only advances on cycles the sweep actually
  // wrote, so renderer reads simply stretch the clear. A second clear_start
  // during the sweep has no effect.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= IDLE;
      clear_cnt    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end
        end
        CLEAR: begin
          if (grant == GNT_CLEAR) begin
            if (clear_cnt == LAST_ADDR) begin
              state        <= IDLE;
              clear_cnt    <= '0;
              clear_done_q <= 1'b1;
            end else begin
              clear_cnt <= clear_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign clearing           = 1'b0;
  assign clear_addr         = '0;
  assign clear_busy         = 1'b0;
  assign clear_done         = 1'b0;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, display-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, character code width.
REQ-003 SHALL have parameter CHARS, default 1200, number of valid cells (40x30).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, CPU write queue depth (power of two).
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port clr, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rd_req, input, 1, renderer fetch strobe.
REQ-008 SHALL have port rd_addr, input, ADDR_W, renderer fetch address.
REQ-009 SHALL have port rd_data, output, DATA_W, fetched character code.
REQ-010 SHALL have port rd_valid, output, 1, rd_data valid pulse.
REQ-011 SHALL have ports cpu_wr_valid (input, 1), cpu_wr_addr (input, ADDR_W), cpu_wr_data (input, DATA_W) and cpu_wr_ready (output, 1), forming the CPU write channel.
REQ-012 SHALL have port wr_drop, output, 1, pulse when a dequeued write has address >= CHARS.
REQ-013 SHALL have ports clear_start (input, 1), clear_busy (output, 1) and clear_done (output, 1 pulse).
REQ-014 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W), forming the synchronous single-port RAM with 1-cycle read latency.

Function
REQ-015 SHALL drive the memory port combinationally from the current-cycle grant, with exactly one grant per cycle.
REQ-016 SHALL give rd_req absolute priority: mem_en=1, mem_we=0, mem_addr=rd_addr in the same cycle.
REQ-017 SHALL register rd_data=mem_rdata with rd_valid=1 exactly one cycle after a granted rd_req; rd_valid is 0 otherwise.
REQ-018 SHALL accept a CPU write into the FIFO when cpu_wr_valid && cpu_wr_ready; cpu_wr_ready = !full.
REQ-019 SHALL allow a simultaneous push and pop; count is unchanged in that case.
REQ-020 SHALL pop the FIFO head in state IDLE when rd_req=0 and the FIFO is non-empty.
REQ-021 SHALL, for a popped head with address < CHARS, issue mem_en=1, mem_we=1, head addr/data; otherwise SHALL perform no memory access and pulse wr_drop for 1 cycle.
REQ-022 SHALL keep FIFO entries in order; no write is lost while cpu_wr_ready=1 at acceptance.
REQ-023 SHALL implement states IDLE and CLEAR: IDLE->CLEAR on clear_start=1 in IDLE; CLEAR->IDLE after the write to address CHARS-1.
REQ-024 SHALL ignore clear_start while in CLEAR.
REQ-025 SHALL, in CLEAR, write 0x20 to an internal address counter starting at 0 on every cycle with rd_req=0, incrementing after each write; FIFO pops are stalled while FIFO pushes continue.
REQ-026 SHALL drive clear_busy=1 throughout CLEAR and pulse clear_done=1 for the cycle after the last clear write.
REQ-027 SHALL ensure that a renderer read issued during CLEAR returns current memory contents (partially cleared screen is legal).

Reset
REQ-028 SHALL, on clr=0, immediately set: state IDLE; FIFO empty; clear counter 0; rd_valid, rd_data, wr_drop, clear_busy and clear_done all 0.
REQ-029 SHALL hold cpu_wr_ready=1 while clr=1 and the FIFO is empty; SHALL drive mem_en=0 during reset.
REQ-030 SHALL, on reset asserted mid-CLEAR, abort the clear with no further writes after release.

Configuration
REQ-031 SHALL compile the CLEAR state, counter and clear_done logic only when macro VRAM_CLEAR_EN is defined.
REQ-032 SHALL, without VRAM_CLEAR_EN, keep all ports, ignore clear_start, and tie clear_busy and clear_done to 0.

Structure
REQ-033 SHALL place state encoding (IDLE, CLEAR), the blank code 0x20 and default CHARS in shared package gpu_pkg.
REQ-034 SHALL implement the write queue as sub-module vram_wr_fifo (push/pop/full/empty, FIFO_DEPTH entries).

Verification
REQ-035 SHALL verify: CPU write addr 5 data 0x41, no rd_req -> mem_we=1 at addr 5 within 2 cycles; later rd_req addr 5 -> rd_valid next cycle, rd_data=0x41.
REQ-036 SHALL verify: rd_req held every cycle for 10 cycles with 3 CPU writes queued -> no mem_we during those cycles; 3 writes issue in order after rd_req drops.
REQ-037 SHALL verify: 5 back-to-back CPU writes with rd_req=1 continuous -> cpu_wr_ready=0 after 4th; 5th held until a pop.
REQ-038 SHALL verify: CPU write addr 1200 -> wr_drop pulses once, no mem_we.
REQ-039 SHALL verify: clear_start with rd_req idle -> 1200 writes of 0x20 at addrs 0..1199, clear_done 1 cycle after last, second clear_start mid-clear ignored.
REQ-040 SHALL verify: clr=0 asserted after clear writes to 600 addresses -> clear_busy=0 immediately; addresses 600..1199 unchanged after release.
